// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns, one column per clock through a shared
// GF(2^8) column multiplier, with a per-block bypass for the final round.
module mix_columns_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] row1,
    input  logic [31:0] row2,
    input  logic [31:0] row3,
    input  logic [31:0] row4,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        bypass,
    output logic [31:0] row1_out,
    output logic [31:0] row2_out,
    output logic [31:0] row3_out,
    output logic [31:0] row4_out,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  col;
    logic [31:0] w0, w1, w2, w3;
    logic [4:0]  sh;
    logic [7:0]  a0, a1, a2, a3, b0, b1, b2, b3;
    logic        load;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // column 0 lives in the top byte, so the bit offset is (3-col)*8
    assign sh = {~col, 3'b000};
    assign a0 = w0[sh +: 8];
    assign a1 = w1[sh +: 8];
    assign a2 = w2[sh +: 8];
    assign a3 = w3[sh +: 8];
    assign b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);

    assign in_ready  = state == IDLE || (state == DONE && out_ready);
    assign load      = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign row1_out  = w0;
    assign row2_out  = w1;
    assign row3_out  = w2;
    assign row4_out  = w3;

    always_comb begin
        state_nx = state;
        state_nx = load ? (bypass ? DONE : BUSY) :
                   (state == BUSY && col == 2'd3) ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col   <= 2'd0;
            w0    <= 32'h0;
            w1    <= 32'h0;
            w2    <= 32'h0;
            w3    <= 32'h0;
        end else begin
            state <= state_nx;
            if (load) begin
                w0  <= row1;
                w1  <= row2;
                w2  <= row3;
                w3  <= row4;
                col <= 2'd0;
            end else if (state == BUSY) begin
                w0[sh +: 8] <= b0;
                w1[sh +: 8] <= b1;
                w2[sh +: 8] <= b2;
                w3[sh +: 8] <= b3;
                col         <= col + 2'd1;
            end
        end
    end
endmodule
